bit_op_ctrl: RTL and testbench

Sequencer that executes 8051 Boolean-processor instructions against the bit-addressable memory. Sits directly upstream of the bit memory and drives its ports:
- chip select (active low), on posedge-registered outputs;
- read/write (high = read, low = write);
- address and write data.

It samples the memory's read data, which the memory updates on negedge. It owns the carry flag C and returns completion status to the instruction decoder via a valid/ready request and a one-cycle done pulse.

---
 rtl/bit_op_pkg.sv | 42 ++++
 rtl/bit_logic.sv | 35 +++
 rtl/bit_op_ctrl.sv | 141 ++++++++++++++
 tb/tb_bit_op_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_op_pkg.sv
// Shared opcode, state and classification definitions for the Boolean-processor
// bit sequencer and its carry/bit logic.
package bit_op_pkg;

    localparam logic [3:0] OP_SETB        = 4'd0;
    localparam logic [3:0] OP_CLR         = 4'd1;
    localparam logic [3:0] OP_CPL         = 4'd2;
    localparam logic [3:0] OP_MOV_C       = 4'd3;
    localparam logic [3:0] OP_MOV_BIT     = 4'd4;
    localparam logic [3:0] OP_ANL         = 4'd5;
    localparam logic [3:0] OP_ORL         = 4'd6;
    localparam logic [3:0] OP_ANL_N       = 4'd7;
    localparam logic [3:0] OP_ORL_N       = 4'd8;
    localparam logic [3:0] OP_SETB_C      = 4'd9;
    localparam logic [3:0] OP_CLR_C       = 4'd10;
    localparam logic [3:0] OP_CPL_C       = 4'd11;
    localparam logic [3:0] OP_LAST_LEGAL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_needs_read(input logic [3:0] op);
        return (op == OP_CPL) || ((op >= OP_MOV_C) && (op <= OP_ORL_N) && (op != OP_MOV_BIT));
    endfunction

    function automatic logic op_needs_write(input logic [3:0] op);
        return (op == OP_SETB) || (op == OP_CLR) || (op == OP_MOV_BIT);
    endfunction

    function automatic logic op_is_carry_only(input logic [3:0] op);
        return (op >= OP_SETB_C) && (op <= OP_LAST_LEGAL);
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/bit_logic.sv
// Combinational core of the Boolean processor: derives the new carry and the
// data to write back from the opcode, the bit read from memory and the current C.
module bit_logic
    import bit_op_pkg::*;
(
    input  logic [3:0] op,
    input  logic       bit_val,
    input  logic       c_in,
    output logic       new_c,
    output logic       c_update,
    output logic       wr_data
);

    always_comb begin
        new_c    = c_in;
        c_update = 1'b0;
        wr_data  = 1'b0;
        case (op)
            OP_SETB:    wr_data = 1'b1;
            OP_CLR:     wr_data = 1'b0;
            OP_CPL:     wr_data = ~bit_val;
            OP_MOV_BIT: wr_data = c_in;
            OP_MOV_C:   begin new_c = bit_val;            c_update = 1'b1; end
            OP_ANL:     begin new_c = c_in & bit_val;     c_update = 1'b1; end
            OP_ORL:     begin new_c = c_in | bit_val;     c_update = 1'b1; end
            OP_ANL_N:   begin new_c = c_in & ~bit_val;    c_update = 1'b1; end
            OP_ORL_N:   begin new_c = c_in | ~bit_val;    c_update = 1'b1; end
            OP_SETB_C:  begin new_c = 1'b1;               c_update = 1'b1; end
            OP_CLR_C:   begin new_c = 1'b0;               c_update = 1'b1; end
            OP_CPL_C:   begin new_c = ~c_in;              c_update = 1'b1; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/bit_op_ctrl.sv
// Sequencer driving the bit-addressable memory for 8051 Boolean instructions;
// owns the carry flag and reports completion to the decoder. All outputs registered.
module bit_op_ctrl
    import bit_op_pkg::*;
#(
    parameter int ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic                 c_wr_en,
    input  logic                 c_wr_data,
    output logic                 c_flag,
    output logic                 done,
    output logic                 err,
    output logic                 rd_bit,
    output logic                 mem_cs_n,
    output logic                 mem_rw,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic                 mem_din,
    input  logic                 mem_dout
);

    state_t               state, state_n;
    logic [3:0]           op_q, op_n;
    logic                 ready_n, c_n, done_n, err_n, rd_bit_n;
    logic                 cs_n_n, rw_n, din_n;
    logic [ADDRWIDTH-1:0] addr_n;

    logic [3:0] lg_op;
    logic       lg_new_c, lg_c_update, lg_wr_data;

    // In IDLE the logic sees the incoming request (carry ops, write data from C
    // at accept); afterwards it works on the latched op and the bit just read.
    assign lg_op = (state == ST_IDLE) ? req_op : op_q;

    bit_logic u_logic (
        .op       (lg_op),
        .bit_val  (mem_dout),
        .c_in     (c_flag),
        .new_c    (lg_new_c),
        .c_update (lg_c_update),
        .wr_data  (lg_wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            req_ready <= 1'b1;
            c_flag    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_bit    <= 1'b0;
            mem_cs_n  <= 1'b1;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_din   <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            req_ready <= ready_n;
            c_flag    <= c_n;
            done      <= done_n;
            err       <= err_n;
            rd_bit    <= rd_bit_n;
            mem_cs_n  <= cs_n_n;
            mem_rw    <= rw_n;
            mem_addr  <= addr_n;
            mem_din   <= din_n;
        end
    end

    always_comb begin
        state_n  = state;
        op_n     = op_q;
        c_n      = c_flag;
        done_n   = 1'b0;
        err_n    = 1'b0;
        rd_bit_n = rd_bit;
        cs_n_n   = 1'b1;
        rw_n     = 1'b1;
        addr_n   = mem_addr;
        din_n    = mem_din;

        // External carry write loses to any op updating C in the same cycle.
        if (c_wr_en)
            c_n = c_wr_data;

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_n = req_op;
                    if (op_needs_read(req_op)) begin
                        state_n = ST_RD;
                        cs_n_n  = 1'b0;
                        addr_n  = req_addr;
                    end else if (op_needs_write(req_op)) begin
                        state_n = ST_WR;
                        cs_n_n  = 1'b0;
                        rw_n    = 1'b0;
                        addr_n  = req_addr;
                        din_n   = lg_wr_data;
                    end else begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        err_n   = op_is_illegal(req_op);
                        if (lg_c_update && op_is_carry_only(req_op))
                            c_n = lg_new_c;
                    end
                end
            end
            ST_RD: begin
                rd_bit_n = mem_dout;
                if (op_q == OP_CPL) begin
                    state_n = ST_WR;
                    cs_n_n  = 1'b0;
                    rw_n    = 1'b0;
                    din_n   = lg_wr_data;
                end else begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    if (lg_c_update)
                        c_n = lg_new_c;
                end
            end
            ST_WR: begin
                state_n = ST_DONE;
                done_n  = 1'b1;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        ready_n = (state_n == ST_IDLE);
    end

endmodule

// File: tb/tb_bit_op_ctrl.sv
// Directed bench for bit_op_ctrl with a behavioural bit memory that reads and
// writes on the negative clock edge.
module tb_bit_op_ctrl;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_addr;
    logic          c_wr_en;
    logic          c_wr_data;
    logic          c_flag;
    logic          done;
    logic          err;
    logic          rd_bit;
    logic          mem_cs_n;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic          mem_din;
    logic          mem_dout = 1'b0;

    logic [7:0]    mem = 8'h00;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic          poke_val = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bit_op_ctrl #(.ADDRWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .c_wr_en(c_wr_en), .c_wr_data(c_wr_data), .c_flag(c_flag),
        .done(done), .err(err), .rd_bit(rd_bit),
        .mem_cs_n(mem_cs_n), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always @(negedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_val;
        else if (!mem_cs_n) begin
            if (mem_rw) mem_dout <= mem[mem_addr];
            else        mem[mem_addr] <= mem_din;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic poke(input logic [AW-1:0] a, input logic v);
        poke_en = 1'b1; poke_addr = a; poke_val = v;
        @(negedge clk); #1;
        poke_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_c(input logic v);
        c_wr_en = 1'b1; c_wr_data = v;
        @(posedge clk); #1;
        c_wr_en = 1'b0;
    endtask

    // Issues one request and observes it until done (bounded); cw_cycle selects
    // the cycle (0 = accept) in which an external carry write is pulsed.
    task automatic run_op(input logic [3:0] op, input logic [AW-1:0] a,
                          input int cw_cycle, input logic cw_data,
                          output int lat, output int nrd, output int nwr,
                          output logic wdin, output logic [AW-1:0] waddr, output logic err_o);
        req_valid = 1'b1; req_op = op; req_addr = a;
        c_wr_en = (cw_cycle == 0); c_wr_data = cw_data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0; wdin = 1'bx; waddr = 'x;
        while (!done) begin
            c_wr_en = (lat == cw_cycle);
            if (!mem_cs_n) begin
                if (mem_rw) nrd++;
                else begin nwr++; wdin = mem_din; waddr = mem_addr; end
            end
            if (lat > 8) break;
            @(posedge clk); #1;
            lat++;
        end
        c_wr_en = 1'b0;
        err_o = err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; c_wr_en = 1'b0; c_wr_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_vec++; if (c_flag !== 1'b0)    begin n_bad++; $display("FAIL reset_c: got %b want 0", c_flag); end
        n_vec++; if (done !== 1'b0 || err !== 1'b0 || rd_bit !== 1'b0) begin n_bad++; $display("FAIL reset_done_err_rd: got %b%b%b want 000", done, err, rd_bit); end
        n_vec++; if (mem_cs_n !== 1'b1 || mem_rw !== 1'b1) begin n_bad++; $display("FAIL reset_cs_rw: got %b%b want 11", mem_cs_n, mem_rw); end
        n_vec++; if (mem_addr !== '0 || mem_din !== 1'b0) begin n_bad++; $display("FAIL reset_addr_din: got %0d/%b want 0/0", mem_addr, mem_din); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_setb_mov();
        int lat, nrd, nwr; logic wd, e; logic [AW-1:0] wa;
        run_op(4'd0, 3'd5, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (lat !== 2)   begin n_bad++; $display("FAIL setb_latency: got %0d want 2", lat); end
        n_vec++; if (e !== 1'b0)  begin n_bad++; $display("FAIL setb_err: got %b want 0", e); end
        n_vec++; if (nwr !== 1 || nrd !== 0) begin n_bad++; $display("FAIL setb_cycles: got wr=%0d rd=%0d want wr=1 rd=0", nwr, nrd); end
        n_vec++; if (wd !== 1'b1 || wa !== 3'd5) begin n_bad++; $display("FAIL setb_wdata: got din=%b addr=%0d want 1/5", wd, wa); end
        run_op(4'd3, 3'd5, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (lat !== 2)   begin n_bad++; $display("FAIL movc_latency: got %0d want 2", lat); end
        n_vec++; if (c_flag !== 1'b1 || rd_bit !== 1'b1) begin n_bad++; $display("FAIL movc_result: got c=%b rd=%b want 1/1", c_flag, rd_bit); end
        n_vec++; if (nrd !== 1 || nwr !== 0) begin n_bad++; $display("FAIL movc_cycles: got rd=%0d wr=%0d want rd=1 wr=0", nrd, nwr); end
    endtask

    task automatic test_cpl();
        int lat, nrd, nwr; logic wd, e; logic [AW-1:0] wa;
        poke(3'd3, 1'b1);
        run_op(4'd2, 3'd3, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (lat !== 3)   begin n_bad++; $display("FAIL cpl_latency: got %0d want 3", lat); end
        n_vec++; if (nrd !== 1 || nwr !== 1 || wd !== 1'b0 || wa !== 3'd3) begin n_bad++; $display("FAIL cpl_seq: got rd=%0d wr=%0d din=%b addr=%0d want 1/1/0/3", nrd, nwr, wd, wa); end
        n_vec++; if (mem[3] !== 1'b0) begin n_bad++; $display("FAIL cpl_mem: got %b want 0", mem[3]); end
        run_op(4'd3, 3'd3, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b0 || rd_bit !== 1'b0) begin n_bad++; $display("FAIL cpl_readback: got c=%b rd=%b want 0/0", c_flag, rd_bit); end
    endtask

    task automatic test_logic_ops();
        int lat, nrd, nwr; logic wd, e; logic [AW-1:0] wa;
        poke(3'd6, 1'b0);
        set_c(1'b1);
        n_vec++; if (c_flag !== 1'b1) begin n_bad++; $display("FAIL ext_c_write: got %b want 1", c_flag); end
        run_op(4'd7, 3'd6, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b1) begin n_bad++; $display("FAIL anl_not: got %b want 1", c_flag); end
        run_op(4'd5, 3'd6, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b0) begin n_bad++; $display("FAIL anl: got %b want 0", c_flag); end
        run_op(4'd6, 3'd6, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b0) begin n_bad++; $display("FAIL orl_zero: got %b want 0", c_flag); end
        run_op(4'd8, 3'd6, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b1 || lat !== 2) begin n_bad++; $display("FAIL orl_not: got c=%b lat=%0d want 1/2", c_flag, lat); end
    endtask

    task automatic test_carry_ops();
        int lat, nrd, nwr; logic wd, e; logic [AW-1:0] wa;
        set_c(1'b0);
        run_op(4'd9, 3'd0, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b1 || lat !== 1 || e !== 1'b0) begin n_bad++; $display("FAIL setb_c: got c=%b lat=%0d err=%b want 1/1/0", c_flag, lat, e); end
        run_op(4'd11, 3'd0, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b0) begin n_bad++; $display("FAIL cpl_c: got %b want 0", c_flag); end
        set_c(1'b1);
        run_op(4'd10, 3'd0, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b0 || nrd + nwr !== 0) begin n_bad++; $display("FAIL clr_c: got c=%b memcycles=%0d want 0/0", c_flag, nrd + nwr); end
    endtask

    task automatic test_mov_bit_c();
        int lat, nrd, nwr; logic wd, e; logic [AW-1:0] wa;
        poke(3'd2, 1'b1);
        set_c(1'b0);
        run_op(4'd4, 3'd2, 0, 1'b1, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (wd !== 1'b0 || wa !== 3'd2 || lat !== 2) begin n_bad++; $display("FAIL movbit_data: got din=%b addr=%0d lat=%0d want 0/2/2", wd, wa, lat); end
        n_vec++; if (mem[2] !== 1'b0) begin n_bad++; $display("FAIL movbit_mem: got %b want 0", mem[2]); end
        n_vec++; if (c_flag !== 1'b1) begin n_bad++; $display("FAIL movbit_c_after: got %b want 1", c_flag); end
    endtask

    task automatic test_priority_illegal();
        int lat, nrd, nwr; logic wd, e; logic [AW-1:0] wa;
        poke(3'd4, 1'b0);
        set_c(1'b1);
        run_op(4'd3, 3'd4, 1, 1'b1, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b0) begin n_bad++; $display("FAIL c_priority: got %b want 0", c_flag); end
        run_op(4'd13, 3'd1, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (lat !== 1 || e !== 1'b1) begin n_bad++; $display("FAIL illegal_done: got lat=%0d err=%b want 1/1", lat, e); end
        n_vec++; if (c_flag !== 1'b0 || nrd + nwr !== 0) begin n_bad++; $display("FAIL illegal_side: got c=%b memcycles=%0d want 0/0", c_flag, nrd + nwr); end
        n_vec++; if (err !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_after: got err=%b ready=%b want 0/1", err, req_ready); end
    endtask

    task automatic test_reset_mid_op();
        int lat, nrd, nwr, seen; logic wd, e; logic [AW-1:0] wa;
        poke(3'd7, 1'b0);
        set_c(1'b1);
        req_valid = 1'b1; req_op = 4'd0; req_addr = 3'd7; rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        n_vec++; if (mem_cs_n !== 1'b1 || mem_rw !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL rst_outputs: got cs=%b rw=%b done=%b want 1/1/0", mem_cs_n, mem_rw, done); end
        n_vec++; if (c_flag !== 1'b0 || req_ready !== 1'b1 || mem_addr !== '0 || mem_din !== 1'b0) begin n_bad++; $display("FAIL rst_state: got c=%b ready=%b addr=%0d din=%b want 0/1/0/0", c_flag, req_ready, mem_addr, mem_din); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || !mem_cs_n) seen++;
            @(posedge clk); #1;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL rst_no_activity: got %0d active cycles want 0", seen); end
        n_vec++; if (mem[7] !== 1'b0) begin n_bad++; $display("FAIL rst_no_write: got %b want 0", mem[7]); end
        set_c(1'b1);
        run_op(4'd3, 3'd7, -1, 1'b0, lat, nrd, nwr, wd, wa, e);
        n_vec++; if (c_flag !== 1'b0 || rd_bit !== 1'b0 || lat !== 2) begin n_bad++; $display("FAIL rst_readback: got c=%b rd=%b lat=%0d want 0/0/2", c_flag, rd_bit, lat); end
    endtask

    initial begin
        test_reset();
        test_setb_mov();
        test_cpl();
        test_logic_ops();
        test_carry_ops();
        test_mov_bit_c();
        test_priority_illegal();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
